// File: rtl/axi_read_arbiter_if.sv
// ============================================================================
// Module   : axi_read_arbiter_if
// Brief    : Fetch/load sram-like read ports plus the shared AXI3 AR/R channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_read_arbiter_if;
  // instruction-fetch port
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  // data-load port
  logic        data_req;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  // AXI3 read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // AXI3 read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  // The arbiter is the AXI master and the responder on both sram-like ports.
  modport master (
    input  inst_req, inst_size, inst_addr,
    input  data_req, data_size, data_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_req, inst_size, inst_addr,
    output data_req, data_size, data_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

`default_nettype wire

// File: rtl/axi_read_arbiter.sv
// ============================================================================
// Module   : axi_read_arbiter
// Brief    : Round-robin arbiter sharing one single-beat AXI3 read channel
//            between instruction-fetch and data-load sram-like ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_read_arbiter #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  axi_read_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_last_data;   // 1: data port won the most recent grant
  logic        r_owner_data;  // 1: transaction in flight belongs to data port
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic [3:0]  r_arid;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_inst_data_ok;
  logic        r_data_data_ok;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;

  logic w_idle;
  logic w_grant_data;
  logic w_grant_inst;
  logic w_unused_r_fields;

  // On a tie the port that did not win last time is served.
  assign w_idle       = (r_state == S_IDLE);
  assign w_grant_data = w_idle & bus.data_req & (~bus.inst_req | ~r_last_data);
  assign w_grant_inst = w_idle & bus.inst_req & ~w_grant_data;

  // Ordering is implied by a single outstanding single-beat read.
  assign w_unused_r_fields = ^{bus.rid, bus.rresp, bus.rlast};

  assign bus.inst_addr_ok = ~reset & w_grant_inst;
  assign bus.data_addr_ok = ~reset & w_grant_data;
  assign bus.inst_data_ok = r_inst_data_ok;
  assign bus.data_data_ok = r_data_data_ok;
  assign bus.inst_rdata   = r_inst_rdata;
  assign bus.data_rdata   = r_data_rdata;

  assign bus.arid    = r_arid;
  assign bus.araddr  = r_araddr;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = r_arsize;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = r_arvalid;
  assign bus.rready  = r_rready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_last_data    <= 1'b0;
      r_owner_data   <= 1'b0;
      r_araddr       <= 32'd0;
      r_arsize       <= 3'd0;
      r_arid         <= 4'd0;
      r_arvalid      <= 1'b0;
      r_rready       <= 1'b0;
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
      r_inst_rdata   <= 32'd0;
      r_data_rdata   <= 32'd0;
    end else begin
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_inst | w_grant_data) begin
            r_owner_data <= w_grant_data;
            r_last_data  <= w_grant_data;
            r_araddr     <= w_grant_data ? bus.data_addr : bus.inst_addr;
            r_arsize     <= {1'b0, (w_grant_data ? bus.data_size : bus.inst_size)};
            r_arid       <= w_grant_data ? ID_DATA : ID_INST;
            r_arvalid    <= 1'b1;
            r_state      <= S_AR;
          end
        end
        S_AR: begin
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (bus.rvalid) begin
            r_rready <= 1'b0;
            if (r_owner_data) begin
              r_data_rdata   <= bus.rdata;
              r_data_data_ok <= 1'b1;
            end else begin
              r_inst_rdata   <= bus.rdata;
              r_inst_data_ok <= 1'b1;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
// ============================================================================
// Module   : tb_axi_read_arbiter
// Brief    : Self-checking bench for axi_read_arbiter against a request-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axi_read_arbiter;

  logic clk = 1'b0;
  logic reset;
  axi_read_arbiter_if bus();

  axi_read_arbiter #(.ID_INST(4'd0), .ID_DATA(4'd1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pending request per port (0 inst, 1 data), last winner, delivered data.
  bit          pend [2];
  logic [31:0] paddr[2];
  logic [1:0]  psize[2];
  logic [31:0] mrd  [2];
  bit          last_data;
  bit          rand_en;
  int          t_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_ports();
    bus.inst_req  = pend[0];
    bus.inst_addr = paddr[0];
    bus.inst_size = psize[0];
    bus.data_req  = pend[1];
    bus.data_addr = paddr[1];
    bus.data_size = psize[1];
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_inst_addr_ok"}, 32'(bus.inst_addr_ok), 32'd0);
    chk({tag, "_data_addr_ok"}, 32'(bus.data_addr_ok), 32'd0);
    chk({tag, "_inst_data_ok"}, 32'(bus.inst_data_ok), 32'd0);
    chk({tag, "_data_data_ok"}, 32'(bus.data_data_ok), 32'd0);
  endtask

  // Called at posedge+1 of an IDLE cycle with at least one request pending.
  task automatic serve(input int ar_st, input int r_st, input logic [31:0] beat,
                       input logic [1:0] resp, input bit keep);
    int          w;
    logic [31:0] a;
    logic [1:0]  s;
    drive_ports();
    #1;
    w = (pend[0] && pend[1]) ? (last_data ? 0 : 1) : (pend[1] ? 1 : 0);
    chk("grant_inst_addr_ok", 32'(bus.inst_addr_ok), 32'(w == 0));
    chk("grant_data_addr_ok", 32'(bus.data_addr_ok), 32'(w == 1));
    chk("idle_inst_data_ok", 32'(bus.inst_data_ok), 32'd0);
    chk("idle_data_data_ok", 32'(bus.data_data_ok), 32'd0);
    last_data = (w == 1);
    a = paddr[w];
    s = psize[w];
    t_grant = cyc;
    if (!keep) pend[w] = 1'b0;

    for (int i = 0; i <= ar_st; i++) begin
      @(posedge clk); #1;
      if (rand_en && !pend[1-w] && $urandom_range(0, 2) == 0) begin
        pend[1-w]  = 1'b1;
        paddr[1-w] = $urandom;
        psize[1-w] = 2'($urandom_range(0, 2));
      end
      drive_ports();
      bus.arready = (i == ar_st);
      #1;
      chk("ar_arvalid", 32'(bus.arvalid), 32'd1);
      chk("ar_araddr", bus.araddr, a);
      chk("ar_arid", 32'(bus.arid), 32'(w));
      chk("ar_arsize", 32'(bus.arsize), 32'({1'b0, s}));
      chk("ar_arlen", 32'(bus.arlen), 32'd0);
      chk("ar_arburst", 32'(bus.arburst), 32'd1);
      chk("ar_fixed", 32'({bus.arlock, bus.arcache, bus.arprot}), 32'd0);
      chk("ar_rready", 32'(bus.rready), 32'd0);
      chk_quiet("ar");
    end

    for (int i = 0; i <= r_st; i++) begin
      @(posedge clk); #1;
      bus.arready = 1'b0;
      bus.rvalid  = (i == r_st);
      bus.rdata   = (i == r_st) ? beat : $urandom;
      bus.rresp   = resp;
      bus.rlast   = 1'b1;
      bus.rid     = 4'(w);
      #1;
      chk("r_rready", 32'(bus.rready), 32'd1);
      chk("r_arvalid", 32'(bus.arvalid), 32'd0);
      chk_quiet("r");
    end

    @(posedge clk); #1;
    bus.rvalid = 1'b0;
    bus.rdata  = $urandom;
    #1;
    mrd[w] = beat;
    chk("done_inst_data_ok", 32'(bus.inst_data_ok), 32'(w == 0));
    chk("done_data_data_ok", 32'(bus.data_data_ok), 32'(w == 1));
    chk("done_inst_rdata", bus.inst_rdata, mrd[0]);
    chk("done_data_rdata", bus.data_rdata, mrd[1]);
    chk("done_latency", 32'(cyc - t_grant), 32'(3 + ar_st + r_st));
    chk("done_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd0);
    chk("done_data_addr_ok", 32'(bus.data_addr_ok), 32'd0);
    chk("done_rready", 32'(bus.rready), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int prev;
    reset = 1'b1;
    rand_en = 1'b0;
    last_data = 1'b0;
    pend = '{0, 0};
    paddr = '{32'd0, 32'd0};
    psize = '{2'd0, 2'd0};
    mrd = '{32'd0, 32'd0};
    bus.arready = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata = 32'd0;
    bus.rresp = 2'd0;
    bus.rlast = 1'b0;
    bus.rid = 4'd0;
    drive_ports();

    // Reset state, with a request held to prove addr_ok stays low.
    @(posedge clk); #1;
    pend[0] = 1'b1; paddr[0] = 32'h0000_1000; psize[0] = 2'd2;
    drive_ports();
    #1;
    chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("rst_rready", 32'(bus.rready), 32'd0);
    chk("rst_araddr", bus.araddr, 32'd0);
    chk("rst_arid", 32'(bus.arid), 32'd0);
    chk("rst_arsize", 32'(bus.arsize), 32'd0);
    chk("rst_inst_rdata", bus.inst_rdata, 32'd0);
    chk("rst_data_rdata", bus.data_rdata, 32'd0);
    chk_quiet("rst");

    // Tie straight after reset: data first, then inst, then a fresh tie goes to data.
    @(posedge clk); #1;
    reset = 1'b0;
    pend[1] = 1'b1; paddr[1] = 32'h0000_2000; psize[1] = 2'd2;
    serve(0, 0, 32'hD000_0001, 2'b00, 1'b0);
    serve(0, 0, 32'h1000_0001, 2'b00, 1'b0);
    pend[0] = 1'b1; paddr[0] = 32'h0000_1004; psize[0] = 2'd2;
    pend[1] = 1'b1; paddr[1] = 32'h0000_2004; psize[1] = 2'd2;
    serve(0, 0, 32'hD000_0002, 2'b00, 1'b0);
    serve(0, 0, 32'h1000_0002, 2'b00, 1'b0);

    // Single instruction read, no stalls.
    pend[0] = 1'b1; paddr[0] = 32'hBFC0_0000; psize[0] = 2'd2;
    serve(0, 0, 32'h3C1D_0001, 2'b00, 1'b0);

    // Stalled data read: 5 AR wait cycles, 3 R wait cycles.
    pend[1] = 1'b1; paddr[1] = 32'h0000_3000; psize[1] = 2'd1;
    serve(5, 3, 32'hCAFE_F00D, 2'b00, 1'b0);

    // Byte load keeps its unaligned address and returns the full beat.
    pend[1] = 1'b1; paddr[1] = 32'h8000_1003; psize[1] = 2'd0;
    serve(0, 0, 32'h1122_3344, 2'b00, 1'b0);

    // Back-to-back instruction reads with req held; the last beat carries SLVERR.
    pend[0] = 1'b1; paddr[0] = 32'h0000_5000; psize[0] = 2'd2;
    serve(0, 0, 32'hAAAA_0001, 2'b00, 1'b1);
    prev = t_grant;
    serve(0, 0, 32'hAAAA_0002, 2'b00, 1'b1);
    chk("b2b_grant_spacing", 32'(t_grant - prev), 32'd4);
    prev = t_grant;
    serve(0, 0, 32'hAAAA_0003, 2'b10, 1'b0);
    chk("b2b_grant_spacing2", 32'(t_grant - prev), 32'd4);

    // Randomized traffic, with new requests arriving mid-transaction.
    rand_en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (!pend[0] && !pend[1]) begin
        int m;
        m = $urandom_range(1, 3);
        for (int p = 0; p < 2; p++) begin
          if (m[p]) begin
            pend[p]  = 1'b1;
            paddr[p] = $urandom;
            psize[p] = 2'($urandom_range(0, 2));
          end
        end
      end
      serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom, 2'($urandom), 1'b0);
    end
    rand_en = 1'b0;
    while (pend[0] || pend[1]) serve(0, 0, $urandom, 2'b00, 1'b0);

    // Reset while in R: outputs drop at once, rdata cleared, no completion.
    pend[0] = 1'b1; paddr[0] = 32'h0000_4000; psize[0] = 2'd2;
    drive_ports();
    #1;
    chk("rr_grant", 32'(bus.inst_addr_ok), 32'd1);
    @(posedge clk); #1;
    bus.arready = 1'b1;
    #1;
    chk("rr_arvalid", 32'(bus.arvalid), 32'd1);
    @(posedge clk); #1;
    bus.arready = 1'b0;
    bus.rvalid = 1'b0;
    #1;
    chk("rr_rready_before", 32'(bus.rready), 32'd1);
    reset = 1'b1;
    #1;
    mrd = '{32'd0, 32'd0};
    last_data = 1'b0;
    chk("rr_rready", 32'(bus.rready), 32'd0);
    chk("rr_arvalid_low", 32'(bus.arvalid), 32'd0);
    chk("rr_inst_rdata", bus.inst_rdata, 32'd0);
    chk("rr_data_rdata", bus.data_rdata, 32'd0);
    chk_quiet("rr");
    @(posedge clk); #1;
    chk_quiet("rr_hold");
    reset = 1'b0;
    serve(0, 0, 32'h5555_AAAA, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares one AXI3 read channel (AR/R) between the CPU's instruction-fetch and data-load sram-like ports. Sits between the core and the AXI bridge on the read side. One transaction outstanding at a time, single-beat bursts; ties resolve round-robin. Writes use a separate path and never enter this block.

## Interface
- ID_INST, 4'd0, arid driven for instruction reads
- ID_DATA, 4'd1, arid driven for data reads
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces all state to reset values
- inst_req / data_req  in  1  read request from fetch / load port
- inst_size / data_size  in  2  bytes = 1<<size (0:1B, 1:2B, 2:4B)
- inst_addr / data_addr  in  32  byte address
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle
- inst_data_ok / data_data_ok  out  1  one-cycle pulse, rdata valid
- inst_rdata / data_rdata  out  32  registered read data, held until next completion on that port
- arid out 4; araddr out 32; arlen out 8; arsize out 3; arburst out 2; arlock out 2; arcache out 4; arprot out 3; arvalid out 1; arready in 1
- rid in 4; rdata in 32; rresp in 2; rlast in 1; rvalid in 1; rready out 1

## Operation
- FSM states: IDLE, AR, R, DONE. Reset state IDLE.
- IDLE: no req -> stay. Exactly one req -> grant it. Both -> grant the port not granted last (last_grant reg, reset value = inst, so first tie goes to data). Grant: addr_ok to winner combinationally in the same cycle (addr_ok = req & IDLE & win); latch addr, size, owner; update last_grant; -> AR. Loser sees addr_ok=0 and must keep req asserted.
- AR: arvalid=1; araddr=latched addr; arsize={1'b0,size}; arid=ID of owner; arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0 (constants). Hold all AR fields stable until arready. arvalid&arready -> R.
- R: rready=1. On rvalid&rready: capture rdata into owner's rdata register; -> DONE. rid, rresp, rlast not checked (single outstanding, single beat guarantees ordering); rresp errors are dropped.
- DONE: owner's data_ok=1 for exactly this cycle; -> IDLE. No grant in DONE.
- Requests arriving in AR/R/DONE: addr_ok=0, req held by requester, served in next IDLE.
- Non-owner rdata register never changes on another port's completion.

## Timing
- Reset values: arvalid 0, rready 0, both addr_ok 0, both data_ok 0, both rdata 0, araddr 0, arid 0, arsize 0; last_grant = inst; state IDLE. addr_ok forced 0 while reset high.
- Best case (arready, rvalid immediate): cycle0 addr_ok; cycle1 arvalid&arready; cycle2 rvalid&rready; cycle3 data_ok; cycle4 IDLE, next addr_ok possible. addr_ok->data_ok = 3 cycles min; throughput 1 read per 4 cycles max.
- arready/rvalid stalls extend AR/R by exactly the stall count; no timeout.
- Reset mid-transaction (AR, R or DONE): return to IDLE asynchronously, arvalid/rready drop immediately, pending data_ok lost; AXI slave is reset concurrently and the in-flight transfer is abandoned.
- addr_ok is combinational on req; data_ok, rdata and all AXI outputs are registered or state-decoded only.

## Test plan
- Single inst read: inst_req, addr 0xBFC00000, size 2, arready/rvalid immediate, rdata 0x3C1D0001 -> addr_ok cycle0, arid 0, arsize 3'b010, arlen 0, arburst 01, inst_data_ok cycle3, inst_rdata 0x3C1D0001, data_rdata stays 0.
- Simultaneous req after reset: both req held, inst 0x1000, data 0x2000 -> data granted first (arid 1, araddr 0x2000), inst granted in next IDLE (arid 0, araddr 0x1000); a third tie then goes to data.
- Stalls: arready low 5 cycles, rvalid low 3 cycles -> araddr/arid/arsize stable throughout AR, rready high throughout R, data_ok exactly 1 cycle, addr_ok->data_ok = 11 cycles.
- Byte load: data_req, addr 0x80001003, size 0 -> arsize 3'b000, araddr 0x80001003 unmodified, data_rdata = full 32-bit rdata beat.
- Reset in R: assert reset while rready=1 -> rready and arvalid 0 same cycle, no data_ok, rdata regs 0; after release, a new inst_req gets addr_ok in first IDLE cycle.
- Back-to-back inst: req held continuously -> addr_ok pulses every 4 cycles, never during AR/R/DONE; rresp=2'b10 on one beat -> data still delivered with data_ok.
